// File: rtl/multicycle_cpu_if.sv
// Instruction-fetch and register-writeback bus of multicycle_cpu.
// The core connects to the slave modport; the instruction source or bench connects to master.
interface multicycle_cpu_if #(
  parameter int DW = 8
);
  logic [7:0]    INSTR;
  logic          INSTR_VALID;
  logic          INSTR_READY;
  logic [7:0]    PC;
  logic [DW-1:0] WB_DATA;
  logic          WB_VALID;
  logic          HALTED;

  modport slave (
    input  INSTR, INSTR_VALID,
    output INSTR_READY, PC, WB_DATA, WB_VALID, HALTED
  );

  modport master (
    output INSTR, INSTR_VALID,
    input  INSTR_READY, PC, WB_DATA, WB_VALID, HALTED
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Four-register multicycle core (FETCH/EXEC/MEM/WB) with a small reset-cleared data memory.
// Define MCPU_HALT_EN to make a self-jump (JMP imm=2'b11) park the core in HALT until reset.
module multicycle_cpu #(
  parameter int DW         = 8,
  parameter int DMEM_DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  multicycle_cpu_if.slave   bus
);

  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    instr_q;
  logic [7:0]    pc_q, pc_d;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] mem_q  [DMEM_DEPTH];
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          wb_valid_q, wb_valid_d;
  logic          instr_ld_s, reg_we_s, mem_we_s;
  logic [1:0]    op_s, rs_s, rt_s, rd_s, dest_s;
  logic [AW-1:0] addr_s;
`ifdef MCPU_HALT_EN
  logic          halted_q, halted_d;
`endif

  function automatic logic [DW-1:0] sext_dw(input logic [1:0] imm);
    return {{(DW-2){imm[1]}}, imm};
  endfunction

  function automatic logic [7:0] sext_pc(input logic [1:0] imm);
    return {{6{imm[1]}}, imm};
  endfunction

  assign op_s   = instr_q[7:6];
  assign rs_s   = instr_q[5:4];
  assign rt_s   = instr_q[3:2];
  assign rd_s   = instr_q[1:0];
  assign dest_s = (op_s == OP_LW) ? rt_s : rd_s;
  // Modulo-DEPTH addressing: only the low AW bits of R[rs]+sext(imm) matter.
  assign addr_s = AW'(regs_q[rs_s] + sext_dw(rd_s));

  // Next-state, PC and writeback decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    instr_ld_s = 1'b0;
    reg_we_s   = 1'b0;
    mem_we_s   = 1'b0;
`ifdef MCPU_HALT_EN
    halted_d   = halted_q;
`endif
    case (state_q)
      FETCH: begin
        if (bus.INSTR_VALID) begin
          instr_ld_s = 1'b1;
          state_d    = EXEC;
        end else begin
          state_d    = FETCH;
        end
      end
      EXEC: begin
        case (op_s)
          OP_ADD: begin
            wb_data_d  = regs_q[rs_s] + regs_q[rt_s];
            wb_valid_d = 1'b1;
            state_d    = WB;
          end
          OP_LW, OP_SW: begin
            state_d = MEM;
          end
          OP_JMP: begin
            pc_d    = pc_q + 8'd1 + sext_pc(rd_s);
            state_d = FETCH;
`ifdef MCPU_HALT_EN
            if (rd_s == 2'b11) begin
              pc_d     = pc_q;
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              state_d  = FETCH;
            end
`endif
          end
          default: begin
            state_d = FETCH;
          end
        endcase
      end
      MEM: begin
        if (op_s == OP_LW) begin
          wb_data_d  = mem_q[addr_s];
          wb_valid_d = 1'b1;
          state_d    = WB;
        end else begin
          mem_we_s = 1'b1;
          pc_d     = pc_q + 8'd1;
          state_d  = FETCH;
        end
      end
      WB: begin
        reg_we_s = 1'b1;
        pc_d     = pc_q + 8'd1;
        state_d  = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // FSM state, PC and the registered writeback strobe/data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= FETCH;
      pc_q       <= 8'h00;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Instruction latch; only loaded on the FETCH handshake.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_q <= 8'h00;
    end else if (instr_ld_s) begin
      instr_q <= bus.INSTR;
    end
  end

  // Register file; written from wb_data_q during the WB cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= DW'(i);
      end
    end else if (reg_we_s) begin
      regs_q[dest_s] <= wb_data_q;
    end
  end

  // Data memory; the SW write lands on the edge that ends MEM.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_q[addr_s] <= regs_q[rt_s];
    end
  end

`ifdef MCPU_HALT_EN
  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign bus.HALTED = halted_q;
`else
  assign bus.HALTED = 1'b0;
`endif

  assign bus.INSTR_READY = (state_q == FETCH);
  assign bus.PC          = pc_q;
  assign bus.WB_DATA     = wb_data_q;
  assign bus.WB_VALID    = wb_valid_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed vector table, random program against an
// architectural model, and hand-written reset/overflow/wrap/halt sequences.
module tb_multicycle_cpu;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic CLK;
  logic RST;

  multicycle_cpu_if #(.DW(DW)) bus ();

  multicycle_cpu #(.DW(DW), .DMEM_DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total;
  int bad;

  // Architectural model state
  logic [DW-1:0] m_r [4];
  logic [DW-1:0] m_m [DEPTH];
  logic [7:0]    m_pc;

  typedef struct {
    logic [7:0]    ins;
    int            cyc;
    bit            wb;
    logic [DW-1:0] data;
    logic [7:0]    pc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = DW'(i);
    for (int i = 0; i < DEPTH; i++) m_m[i] = '0;
    m_pc = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] ins, output int cyc, output bit wb,
                            output logic [DW-1:0] d);
    int op, rs, rt, rd, simm, a;
    op   = int'(ins[7:6]);
    rs   = int'(ins[5:4]);
    rt   = int'(ins[3:2]);
    rd   = int'(ins[1:0]);
    simm = ins[1] ? rd - 4 : rd;
    a    = ((int'(m_r[rs]) + simm) % DEPTH + DEPTH) % DEPTH;
    wb   = 1'b0;
    d    = '0;
    case (op)
      0: begin
        d = m_r[rs] + m_r[rt];
        m_r[rd] = d;
        wb = 1'b1; cyc = 3; m_pc = m_pc + 8'd1;
      end
      1: begin
        d = m_m[a];
        m_r[rt] = d;
        wb = 1'b1; cyc = 4; m_pc = m_pc + 8'd1;
      end
      2: begin
        m_m[a] = m_r[rt];
        cyc = 3; m_pc = m_pc + 8'd1;
      end
      default: begin
        cyc = 2;
        m_pc = 8'((int'(m_pc) + 1 + simm + 256) % 256);
      end
    endcase
  endtask

  task automatic do_reset();
    bus.INSTR_VALID = 1'b0;
    bus.INSTR = 8'h00;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
  endtask

  // Issues one instruction and observes it until the core is back in FETCH.
  task automatic run_instr(input logic [7:0] ins, output int cyc, output int wbn,
                           output logic [DW-1:0] d, output int wbc);
    int guard = 0;
    int cur;
    bit done = 1'b0;
    cyc = 0; wbn = 0; d = '0; wbc = 0;
    while (bus.INSTR_READY !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (bus.INSTR_READY !== 1'b1) begin
      chk("ready_timeout", 32'(bus.INSTR_READY), 32'd1);
      return;
    end
    bus.INSTR = ins;
    bus.INSTR_VALID = 1'b1;
    cyc = 1;
    @(posedge CLK);
    #1;
    bus.INSTR = 8'($urandom);
    bus.INSTR_VALID = 1'($urandom);
    guard = 0;
    while (guard < 20) begin
      @(negedge CLK);
      guard++;
      cur = cyc + 1;
      if (bus.WB_VALID === 1'b1) begin
        wbn++;
        d = bus.WB_DATA;
        wbc = cur;
      end
      if (bus.INSTR_READY === 1'b1) begin
        bus.INSTR_VALID = 1'b0;
        done = 1'b1;
        break;
      end
      cyc = cur;
      bus.INSTR = 8'($urandom);
      bus.INSTR_VALID = 1'($urandom);
    end
    if (!done) begin
      bus.INSTR_VALID = 1'b0;
      chk("done_timeout", 32'(bus.INSTR_READY), 32'd1);
    end
  endtask

  task automatic run_and_check(input string name, input logic [7:0] ins, input int ecyc,
                               input bit ewb, input logic [DW-1:0] edata, input logic [7:0] epc);
    int cyc, wbn, wbc;
    logic [DW-1:0] d;
    run_instr(ins, cyc, wbn, d, wbc);
    chk({name, "_cycles"}, 32'(cyc), 32'(ecyc));
    chk({name, "_wbcount"}, 32'(wbn), ewb ? 32'd1 : 32'd0);
    if (ewb) begin
      chk({name, "_wbdata"}, 32'(d), 32'(edata));
      chk({name, "_wbcycle"}, 32'(wbc), 32'(ecyc));
    end
    chk({name, "_pc"}, 32'(bus.PC), 32'(epc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    bit ewb;
    logic [DW-1:0] ed;
    logic [7:0] ins;
    logic [7:0] ovf [7];
    bit seen;
    bit ok;

    total = 0;
    bad = 0;
    RST = 1'b0;
    bus.INSTR = 8'h00;
    bus.INSTR_VALID = 1'b0;
    model_reset();

    tbl[0] = '{ins: 8'h1B, cyc: 3, wb: 1'b1, data: 8'h03, pc: 8'h01};
    tbl[1] = '{ins: 8'h98, cyc: 3, wb: 1'b0, data: 8'h00, pc: 8'h02};
    tbl[2] = '{ins: 8'h5C, cyc: 4, wb: 1'b1, data: 8'h02, pc: 8'h03};
    tbl[3] = '{ins: 8'h1B, cyc: 3, wb: 1'b1, data: 8'h03, pc: 8'h04};
    tbl[4] = '{ins: 8'h00, cyc: 3, wb: 1'b1, data: 8'h00, pc: 8'h05};
    tbl[5] = '{ins: 8'hC1, cyc: 2, wb: 1'b0, data: 8'h00, pc: 8'h07};
    tbl[6] = '{ins: 8'h5F, cyc: 4, wb: 1'b1, data: 8'h00, pc: 8'h08};
    tbl[7] = '{ins: 8'hB6, cyc: 3, wb: 1'b0, data: 8'h00, pc: 8'h09};
    tbl[8] = '{ins: 8'h4A, cyc: 4, wb: 1'b1, data: 8'h01, pc: 8'h0A};
    tbl[9] = '{ins: 8'h26, cyc: 3, wb: 1'b1, data: 8'h02, pc: 8'h0B};

    ovf[0] = 8'h06; ovf[1] = 8'h0C; ovf[2] = 8'h18; ovf[3] = 8'h30;
    ovf[4] = 8'h60; ovf[5] = 8'hC0; ovf[6] = 8'h80;

    // Reset values while RST is held low
    repeat (2) @(negedge CLK);
    chk("rst_pc", 32'(bus.PC), 32'h00);
    chk("rst_wbvalid", 32'(bus.WB_VALID), 32'd0);
    chk("rst_wbdata", 32'(bus.WB_DATA), 32'h00);
    chk("rst_halted", 32'(bus.HALTED), 32'd0);
    chk("rst_ready", 32'(bus.INSTR_READY), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", 32'(bus.INSTR_READY), 32'd1);

    // Directed vector table; model kept in step for the random phase
    for (int i = 0; i < 10; i++) begin
      model_step(tbl[i].ins, cyc, ewb, ed);
      run_and_check($sformatf("vec%0d", i), tbl[i].ins, tbl[i].cyc, tbl[i].wb,
                    tbl[i].data, tbl[i].pc);
    end

    // Random program against the model
    for (int i = 0; i < 200; i++) begin
      ins = 8'($urandom);
`ifdef MCPU_HALT_EN
      if (ins[7:6] == 2'b11 && ins[1:0] == 2'b11) ins[0] = 1'b0;
`endif
      model_step(ins, cyc, ewb, ed);
      run_and_check($sformatf("rnd%0d_%02h", i, ins), ins, cyc, ewb, ed, m_pc);
    end

    // Overflow: repeated R3 = R3 + R3
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_and_check($sformatf("ovf%0d", i), 8'h3F, 3, 1'b1, ovf[i], 8'(i + 1));
    end

    // Jump backwards past zero, then PC increment wrapping forward
    do_reset();
    run_and_check("jmp_wrap", 8'hC2, 2, 1'b0, 8'h00, 8'hFF);
    run_and_check("pc_wrap", 8'h00, 3, 1'b1, 8'h00, 8'h00);

    // Reset asserted during MEM of LW 0x5C
    do_reset();
    seen = 1'b0;
    bus.INSTR = 8'h5C;
    bus.INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    seen = seen | bus.WB_VALID;
    @(negedge CLK);
    seen = seen | bus.WB_VALID;
    chk("midlw_in_mem_ready", 32'(bus.INSTR_READY), 32'd0);
    RST = 1'b0;
    #1;
    seen = seen | bus.WB_VALID;
    @(negedge CLK);
    seen = seen | bus.WB_VALID;
    RST = 1'b1;
    model_reset();
    chk("midlw_pc", 32'(bus.PC), 32'h00);
    chk("midlw_ready", 32'(bus.INSTR_READY), 32'd1);
    @(negedge CLK);
    seen = seen | bus.WB_VALID;
    chk("midlw_no_wb", 32'(seen), 32'd0);
    run_and_check("midlw_r3", 8'h3F, 3, 1'b1, 8'h06, 8'h01);

    // Self-jump at PC 0x04
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_and_check($sformatf("pre_halt%0d", i), 8'h00, 3, 1'b1, 8'h00, 8'(i + 1));
    end
`ifdef MCPU_HALT_EN
    bus.INSTR = 8'hC3;
    bus.INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1;
    ok = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      bus.INSTR = 8'($urandom);
      bus.INSTR_VALID = 1'b1;
      @(negedge CLK);
      if (bus.HALTED !== 1'b1 || bus.INSTR_READY !== 1'b0 || bus.PC !== 8'h04 ||
          bus.WB_VALID !== 1'b0) ok = 1'b0;
    end
    chk("halt_hold", 32'(ok), 32'd1);
    chk("halt_pc", 32'(bus.PC), 32'h04);
    do_reset();
    chk("halt_cleared", 32'(bus.HALTED), 32'd0);
    chk("halt_rst_ready", 32'(bus.INSTR_READY), 32'd1);
`else
    ok = 1'b1;
    run_and_check("selfjmp", 8'hC3, 2, 1'b0, 8'h00, 8'h04);
    chk("selfjmp_ready", 32'(bus.INSTR_READY), 32'(ok));
    chk("selfjmp_halted", 32'(bus.HALTED), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
